// File: rtl/fmul_rr_sched.sv
// Round-robin sharing of one combinational fp32 multiplier among N_REQ requesters; 2-cycle latency, 1 op/cycle.
// resp_ready low stalls S2 then S1; with both full every req_ready drops.
module fmul_rr_sched #(
  parameter int N_REQ = 4,
  parameter int BIT_W = 32,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*BIT_W-1:0] req_a,
  input  logic [N_REQ*BIT_W-1:0] req_b,
  output logic [BIT_W-1:0]       mul_a,
  output logic [BIT_W-1:0]       mul_b,
  input  logic [BIT_W-1:0]       mul_result,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [BIT_W-1:0]       resp_data,
  output logic [CNT_W-1:0]       done_cnt,
  output logic                   busy
);

  logic             s1_valid;
  logic [ID_W-1:0]  s1_id;
  logic [BIT_W-1:0] s1_a;
  logic [BIT_W-1:0] s1_b;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  ptr_next;
  logic             grant_found;
  logic             s1_adv;
  logic             s2_adv;
  logic             xfer;
  logic [N_REQ-1:0] ready_c;

  assign s2_adv = !resp_valid || resp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // First requesting channel at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  assign xfer = grant_found && s1_adv && !rst;

  always_comb begin
    ready_c = '0;
    if (xfer) ready_c[grant_id] = 1'b1;
  end

  assign req_ready = ready_c;
  assign ptr_next  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      done_cnt   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= xfer;
        if (xfer) begin
          s1_a   <= req_a[grant_id*BIT_W +: BIT_W];
          s1_b   <= req_b[grant_id*BIT_W +: BIT_W];
          s1_id  <= grant_id;
          rr_ptr <= ptr_next;
        end
      end
      if (s2_adv) begin
        resp_valid <= s1_valid;
        if (s1_valid) begin
          resp_data <= mul_result;
          resp_id   <= s1_id;
        end
      end
      if (resp_valid && resp_ready) done_cnt <= done_cnt + 1'b1;
    end
  end

  assign mul_a = s1_a;
  assign mul_b = s1_b;
  assign busy  = s1_valid || resp_valid;

endmodule

// File: tb/tb_fmul_rr_sched.sv
// Directed bench for fmul_rr_sched with a behavioural fp32 multiplier on the mul_* loop.
module tb_fmul_rr_sched;
  localparam int N_REQ = 4;
  localparam int BIT_W = 32;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*BIT_W-1:0] req_a;
  logic [N_REQ*BIT_W-1:0] req_b;
  logic [BIT_W-1:0]       mul_a;
  logic [BIT_W-1:0]       mul_b;
  logic [BIT_W-1:0]       mul_result;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic [BIT_W-1:0]       resp_data;
  logic [CNT_W-1:0]       done_cnt;
  logic                   busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] b_tab [4] = '{32'h40000000, 32'h40800000, 32'h41000000, 32'h41800000};

  fmul_rr_sched #(.N_REQ(N_REQ), .BIT_W(BIT_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .done_cnt(done_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Normal-number fp32 multiply with truncation; zero operands give signed zero.
  function automatic logic [31:0] fmul_m(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [9:0]  e;
    logic [47:0] m;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (m[47]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    return {s, e[7:0], m[45:23]};
  endfunction

  assign mul_result = fmul_m(mul_a, mul_b);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[id*BIT_W +: BIT_W] = a;
    req_b[id*BIT_W +: BIT_W] = b;
  endtask

  // One isolated transaction: grant, one cycle in S1, response, handshake.
  task automatic do_single(input string tag, input int id, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_cnt);
    logic [N_REQ-1:0] onehot;
    onehot = '0;
    onehot[id] = 1'b1;
    set_ops(id, a, b);
    req_valid  = onehot;
    resp_ready = 1'b0;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(onehot));
    tick();
    req_valid = '0;
    #1;
    chk({tag, "_s1_only"}, {63'd0, resp_valid}, 64'd0);
    chk({tag, "_mul_a"}, 64'(mul_a), 64'(a));
    tick();
    chk({tag, "_rvalid"}, {63'd0, resp_valid}, 64'd1);
    chk({tag, "_rid"}, 64'(resp_id), 64'(id));
    chk({tag, "_rdata"}, 64'(resp_data), 64'(exp));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "_cnt"}, 64'(done_cnt), 64'(exp_cnt));
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rvalid", {63'd0, resp_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cnt", 64'(done_cnt), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    req_valid = '0;
    rst = 1'b0;
    #1;

    do_single("single", 2, 32'h3F800000, 32'h40000000, 32'h40000000, 1);
    do_single("sign",   0, 32'hBF800000, 32'h40000000, 32'hC0000000, 2);
    do_single("zero",   0, 32'h00000000, 32'h40000000, 32'h00000000, 3);

    // Fairness: all requesters held valid, pointer restarted at 0.
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_ops(i, 32'h3F800000, b_tab[i]);
    req_valid  = '1;
    resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("fair_grant%0d", c), 64'(req_ready), 64'(1 << (c % 4)));
      if (c >= 2) begin
        chk($sformatf("fair_rvalid%0d", c), {63'd0, resp_valid}, 64'd1);
        chk($sformatf("fair_rid%0d", c), 64'(resp_id), 64'((c - 2) % 4));
        chk($sformatf("fair_rdata%0d", c), 64'(resp_data), 64'(b_tab[(c - 2) % 4]));
      end
      tick();
    end
    chk("fair_cnt", 64'(done_cnt), 64'd4);

    // Backpressure: S2 holds id0, S1 holds id1.
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_ready%0d", c), 64'(req_ready), 64'd0);
      chk($sformatf("bp_rid%0d", c), 64'(resp_id), 64'd0);
      chk($sformatf("bp_rdata%0d", c), 64'(resp_data), 64'(b_tab[0]));
      chk($sformatf("bp_mul_b%0d", c), 64'(mul_b), 64'(b_tab[1]));
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_grant", 64'(req_ready), 64'b0100);
    chk("bp_release_rid", 64'(resp_id), 64'd0);
    tick();
    chk("bp_next_rid", 64'(resp_id), 64'd1);
    chk("bp_next_rdata", 64'(resp_data), 64'(b_tab[1]));
    chk("bp_next_grant", 64'(req_ready), 64'b1000);
    tick();
    chk("bp_after_rid", 64'(resp_id), 64'd2);
    chk("bp_after_cnt", 64'(done_cnt), 64'd6);
    req_valid = '0;
    tick();
    chk("drain_rid", 64'(resp_id), 64'd3);
    tick();
    chk("drain_idle", {63'd0, busy}, 64'd0);
    chk("drain_cnt", 64'(done_cnt), 64'd8);

    // Reset with both stages full.
    resp_ready = 1'b0;
    req_valid  = '1;
    tick();
    tick();
    chk("full_rvalid", {63'd0, resp_valid}, 64'd1);
    chk("full_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    tick();
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_rvalid", {63'd0, resp_valid}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_cnt", 64'(done_cnt), 64'd0);
    rst = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("post_rst_grant3", 64'(req_ready), 64'b1000);

    // Counter wrap: 16 handshakes on a 4-bit counter.
    do_reset();
    req_valid  = '1;
    resp_ready = 1'b1;
    for (int t = 0; t < 18; t++) begin
      tick();
      if (t == 16) chk("wrap_cnt15", 64'(done_cnt), 64'd15);
    end
    chk("wrap_cnt0", 64'(done_cnt), 64'd0);
    chk("wrap_rvalid", {63'd0, resp_valid}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
